// File: rtl/adder_bist_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_bist_pkg
// Brief    : Shared types and constants for the adder BIST sweeper.
// Revision : 1.0 - initial release
// ============================================================================
package adder_bist_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Mismatch counter must hold 2^(2*WIDTH) without ever wrapping.
    function automatic int err_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_bist_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_bist_sweeper_if
// Brief    : Control/result bundle between the BIST engine and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_bist_sweeper_if
    import adder_bist_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int EW = err_width(WIDTH);

    logic             start;
    logic             compare_in;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [EW-1:0]    err_count;
    logic             fail_valid;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    modport master (
        input  start, compare_in,
        output a_out, b_out, busy, done, pass, err_count,
               fail_valid, fail_a, fail_b
    );

    modport slave (
        output start, compare_in,
        input  a_out, b_out, busy, done, pass, err_count,
               fail_valid, fail_a, fail_b
    );
endinterface
`default_nettype wire

// File: rtl/adder_bist_sweeper_counter.sv
`default_nettype none
// ============================================================================
// Module   : operand_pair_counter
// Brief    : (A, B) pair counter; B is the fast digit, A steps on B wrap.
// Revision : 1.0 - initial release
// ============================================================================
module operand_pair_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             advance,
    output logic      [WIDTH-1:0] a,
    output logic      [WIDTH-1:0] b,
    output logic                  last
);
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_a <= '0;
            r_b <= '0;
        end else if (advance) begin
            r_b <= r_b + WIDTH'(1);
            if (r_b == '1) begin
                r_a <= r_a + WIDTH'(1);
            end
        end
    end

    assign a    = r_a;
    assign b    = r_b;
    assign last = (r_a == '1) && (r_b == '1);
endmodule
`default_nettype wire

// File: rtl/adder_bist_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : adder_bist_sweeper
// Brief    : Exhaustive operand sweep with mismatch count and first-fail capture.
// Revision : 1.0 - initial release
// ============================================================================
module adder_bist_sweeper
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    adder_bist_sweeper_if.master bus
);
    localparam int EW = err_width(WIDTH);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] c_SETTLE_LOAD = SW'(SETTLE - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [SW-1:0]    r_settle;
    logic [EW-1:0]    r_err_count;
    logic             r_fail_valid;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;

    logic             w_accept;
    logic             w_sample;
    logic             w_advance;
    logic             w_last;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The final pair is sampled but never advanced, so operands rest at (max, max).
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_settle == '0) begin
                    w_sample = 1'b1;
                    if (w_last) begin
                        w_state_next = DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    operand_pair_counter #(
        .WIDTH (WIDTH)
    ) u_pair_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept),
        .advance (w_advance),
        .a       (w_a),
        .b       (w_b),
        .last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle     <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else if (w_accept) begin
            r_settle     <= c_SETTLE_LOAD;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else if (r_state == RUN) begin
            if (!w_sample) begin
                r_settle <= r_settle - SW'(1);
            end else begin
                r_settle <= c_SETTLE_LOAD;
                if (!bus.compare_in) begin
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + EW'(1);
                    end
                    if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_a     <= w_a;
                        r_fail_b     <= w_b;
                    end
                end
            end
        end
    end

    assign bus.a_out      = w_a;
    assign bus.b_out      = w_b;
    assign bus.busy       = (r_state == RUN);
    assign bus.done       = (r_state == DONE);
    assign bus.pass       = (r_state == DONE) && (r_err_count == '0);
    assign bus.err_count  = r_err_count;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_a     = r_fail_a;
    assign bus.fail_b     = r_fail_b;
endmodule
`default_nettype wire
